// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Round-robin arbiter sharing one regfile write port among
//                NREQ valid/ready requesters. Also owns regfile
//                initialisation: a full clear sweep after reset and on
//                i_init_start.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
    parameter  int NREQ   = 4,
    parameter  int N      = 32,
    parameter  int DWIDTH = 32,
    localparam int AWIDTH = $clog2(N),
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_init_start,
    output logic                     o_init_busy,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic [NREQ*AWIDTH-1:0]   i_req_addr,
    input  logic [NREQ*DWIDTH-1:0]   i_req_data,
    output logic                     o_wr_en,
    output logic [AWIDTH-1:0]        o_wr_addr,
    output logic [DWIDTH-1:0]        o_wr_data,
    output logic [IDW-1:0]           o_grant_id,
    output logic                     o_err_oob
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_clr_cnt;
    logic [IDW-1:0]      r_rr_ptr;

    logic                w_found;
    logic [IDW-1:0]      w_gnt;
    logic [IDW-1:0]      w_idx;
    logic [IDW-1:0]      w_rr_nxt;
    logic                w_accept;
    logic                w_clr_last;
    logic                w_oob;
    logic [AWIDTH-1:0]   w_gnt_addr;
    logic [DWIDTH-1:0]   w_gnt_data;

    // Round-robin search: first valid requester starting at the pointer
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = IDW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_gnt_addr = i_req_addr[int'(w_gnt)*AWIDTH +: AWIDTH];
    assign w_gnt_data = i_req_data[int'(w_gnt)*DWIDTH +: DWIDTH];
    assign w_rr_nxt   = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;
    assign w_clr_last = (r_clr_cnt == AWIDTH'(N-1));

    // Out-of-range addresses only exist when N is not a power of two
    generate
        if (N < (1 << AWIDTH)) begin : g_oob_chk
            assign w_oob = (w_gnt_addr >= AWIDTH'(N));
        end else begin : g_oob_none
            assign w_oob = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grant and busy flag; init request beats any write request
    always_comb begin
        w_state_nxt = r_state;
        o_init_busy = 1'b0;
        o_req_ready = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_INIT: begin
                o_init_busy = 1'b1;
                if (w_clr_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_init_start) begin
                    w_state_nxt = ST_INIT;
                end else if (w_found) begin
                    o_req_ready[w_gnt] = 1'b1;
                    w_accept           = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Registered write port, clear counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt  <= '0;
            r_rr_ptr   <= '0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_grant_id <= '0;
            o_err_oob  <= 1'b0;
        end else begin
            o_err_oob <= 1'b0;
            if (r_state == ST_INIT) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= r_clr_cnt;
                o_wr_data <= '0;
                r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
            end else if (w_accept) begin
                r_rr_ptr   <= w_rr_nxt;
                o_grant_id <= w_gnt;
                if (w_oob) begin
                    // Consumed but dropped: flag it, leave the port idle
                    o_wr_en   <= 1'b0;
                    o_err_oob <= 1'b1;
                end else begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= w_gnt_addr;
                    o_wr_data <= w_gnt_data;
                end
            end else begin
                o_wr_en <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
//  Module      : tb_regfile_wr_arbiter
//  Description : Directed self-checking bench for regfile_wr_arbiter.
//                Instance A uses N=32, instance B uses N=20.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic clk;

    logic                 a_rst_n, a_init_start, a_init_busy, a_wr_en, a_err_oob;
    logic [NREQ-1:0]      a_valid, a_ready;
    logic [NREQ*AW-1:0]   a_addr;
    logic [NREQ*DW-1:0]   a_data;
    logic [AW-1:0]        a_wr_addr;
    logic [DW-1:0]        a_wr_data;
    logic [1:0]           a_grant;

    logic                 b_rst_n, b_init_start, b_init_busy, b_wr_en, b_err_oob;
    logic [NREQ-1:0]      b_valid, b_ready;
    logic [NREQ*AW-1:0]   b_addr;
    logic [NREQ*DW-1:0]   b_data;
    logic [AW-1:0]        b_wr_addr;
    logic [DW-1:0]        b_wr_data;
    logic [1:0]           b_grant;

    int n_vec  = 0;
    int n_fail = 0;

    regfile_wr_arbiter #(.NREQ(NREQ), .N(32), .DWIDTH(DW)) u_dut_a (
        .clk          (clk),
        .rst_n        (a_rst_n),
        .i_init_start (a_init_start),
        .o_init_busy  (a_init_busy),
        .i_req_valid  (a_valid),
        .o_req_ready  (a_ready),
        .i_req_addr   (a_addr),
        .i_req_data   (a_data),
        .o_wr_en      (a_wr_en),
        .o_wr_addr    (a_wr_addr),
        .o_wr_data    (a_wr_data),
        .o_grant_id   (a_grant),
        .o_err_oob    (a_err_oob)
    );

    regfile_wr_arbiter #(.NREQ(NREQ), .N(20), .DWIDTH(DW)) u_dut_b (
        .clk          (clk),
        .rst_n        (b_rst_n),
        .i_init_start (b_init_start),
        .o_init_busy  (b_init_busy),
        .i_req_valid  (b_valid),
        .o_req_ready  (b_ready),
        .i_req_addr   (b_addr),
        .i_req_data   (b_data),
        .o_wr_en      (b_wr_en),
        .o_wr_addr    (b_wr_addr),
        .o_wr_data    (b_wr_data),
        .o_grant_id   (b_grant),
        .o_err_oob    (b_err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int glist [5];
        glist = '{0, 1, 2, 3, 0};

        a_rst_n = 1'b1; a_init_start = 1'b0; a_valid = '0;
        b_rst_n = 1'b1; b_init_start = 1'b0; b_valid = '0;
        b_addr = '0; b_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            a_addr[k*AW +: AW] = AW'(k + 3);
            a_data[k*DW +: DW] = 32'hA000_0000 + DW'(k);
        end

        // Asynchronous reset assertion, checked before any clock edge
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        chk("rst_wr_en",   a_wr_en,     0);
        chk("rst_wr_addr", a_wr_addr,   0);
        chk("rst_wr_data", a_wr_data,   0);
        chk("rst_grant",   a_grant,     0);
        chk("rst_err_oob", a_err_oob,   0);
        chk("rst_ready",   a_ready,     0);
        chk("rst_busy",    a_init_busy, 1);
        step();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        a_valid = 4'b1111;

        // Reset sweep: 32 clears, requests held off until the sweep ends
        for (int i = 0; i < 32; i++) begin
            step();
            chk("init_wr_en",   a_wr_en,   1);
            chk("init_wr_addr", a_wr_addr, i);
            chk("init_wr_data", a_wr_data, 0);
            if (i < 31) begin
                chk("init_ready", a_ready,     0);
                chk("init_busy",  a_init_busy, 1);
            end else begin
                chk("init_done_busy",  a_init_busy, 0);
                chk("init_done_ready", a_ready,     4'b0001);
            end
            if (i == 19) begin
                chk("b_init_last_addr", b_wr_addr,   19);
                chk("b_init_done_busy", b_init_busy, 0);
            end
        end

        // All requesters valid: strict rotation 0,1,2,3,0
        for (int j = 0; j < 5; j++) begin
            chk("rr_ready", a_ready, 4'b0001 << glist[j]);
            step();
            chk("rr_wr_en",   a_wr_en,   1);
            chk("rr_wr_addr", a_wr_addr, glist[j] + 3);
            chk("rr_wr_data", a_wr_data, 32'hA000_0000 + glist[j]);
            chk("rr_grant",   a_grant,   glist[j]);
        end
        a_valid = '0;
        step();
        chk("idle_wr_en",   a_wr_en,   0);
        chk("idle_grant",   a_grant,   0);
        chk("idle_wr_addr", a_wr_addr, 3);

        // Single requester 2
        a_valid = 4'b0100;
        a_addr[2*AW +: AW] = 5'd5;
        a_data[2*DW +: DW] = 32'hDEAD_BEEF;
        #1;
        chk("solo_ready", a_ready, 4'b0100);
        step();
        a_valid = '0;
        chk("solo_wr_en",   a_wr_en,   1);
        chk("solo_wr_addr", a_wr_addr, 5);
        chk("solo_wr_data", a_wr_data, 32'hDEAD_BEEF);
        chk("solo_grant",   a_grant,   2);

        // init_start beats pending requests; pointer survives the sweep
        a_valid = 4'b0011;
        a_init_start = 1'b1;
        #1;
        chk("istart_ready", a_ready, 0);
        step();
        a_init_start = 1'b0;
        chk("istart_wr_en", a_wr_en,     0);
        chk("istart_busy",  a_init_busy, 1);
        for (int i = 0; i < 32; i++) begin
            step();
            chk("resweep_wr_en",   a_wr_en,   1);
            chk("resweep_wr_addr", a_wr_addr, i);
            if (i < 31) chk("resweep_ready", a_ready, 0);
        end
        chk("post_sweep_ready", a_ready, 4'b0001);
        step();
        a_valid = '0;
        chk("post_sweep_grant",   a_grant,   0);
        chk("post_sweep_wr_addr", a_wr_addr, 3);
        chk("post_sweep_wr_data", a_wr_data, 32'hA000_0000);

        // Reset in the middle of a sweep, then restart from address 0
        a_init_start = 1'b1;
        step();
        a_init_start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            step();
            chk("part_wr_addr", a_wr_addr, i);
        end
        #1;
        a_rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en",   a_wr_en,     0);
        chk("mid_rst_wr_addr", a_wr_addr,   0);
        chk("mid_rst_busy",    a_init_busy, 1);
        step();
        a_rst_n = 1'b1;
        step();
        chk("restart_wr_en",   a_wr_en,   1);
        chk("restart_wr_addr0", a_wr_addr, 0);
        step();
        chk("restart_wr_addr1", a_wr_addr, 1);

        // N=20: out-of-range accept is consumed and flagged, then normal grant
        b_valid = 4'b0001;
        b_addr[0 +: AW] = 5'd25;
        b_data[0 +: DW] = 32'h0000_0055;
        #1;
        chk("oob_ready", b_ready, 4'b0001);
        step();
        b_valid = 4'b0010;
        b_addr[AW +: AW] = 5'd7;
        b_data[DW +: DW] = 32'h0000_1234;
        chk("oob_err",   b_err_oob, 1);
        chk("oob_wr_en", b_wr_en,   0);
        #1;
        chk("oob_next_ready", b_ready, 4'b0010);
        step();
        b_valid = '0;
        chk("oob_err_clear",  b_err_oob, 0);
        chk("oob_next_wr_en", b_wr_en,   1);
        chk("oob_next_addr",  b_wr_addr, 7);
        chk("oob_next_data",  b_wr_data, 32'h0000_1234);
        chk("oob_next_grant", b_grant,   1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
